alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with the two operands from the ID/EX pipeline register.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) return a registered result after 1 cycle.
- MUL (code 4'b1111) runs as an iterative radix-2 shift-add with early termination, and holds off upstream via busy_o.
- Output feeds the EX/MEM register and the branch-equal zero path.

Parameters:
- WIDTH, 32, operand/result width in bits; also the worst-case multiply step count.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  operation request; sampled only when busy_o=0
- ctrl_i  in  4  ALU control code
- src1_i  in  WIDTH  operand A (multiplicand for MUL)
- src2_i  in  WIDTH  operand B (multiplier for MUL)
- result_o  out  WIDTH  registered result; holds until next done_o
- zero_o  out  1  registered (result_o==0), updated with result_o
- done_o  out  1  one-cycle pulse: result_o/zero_o just updated
- busy_o  out  1  high while a multiply is in progress

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, result_o=0, zero_o=0, done_o=0, busy_o=0, internal accumulator/counter cleared. Reset mid-multiply aborts it; no done_o is produced.
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD, wraps mod 2^WIDTH, no overflow flag
  - 0110 SUB (A-B), wraps
  - 0111 SLT signed: result 1 if $signed(A)<$signed(B), else 0
  - 1111 MUL: low WIDTH bits of A*B, unsigned product (equal to signed low bits)
  - Any other code: result 0, zero_o=1, done_o pulses normally
- States: IDLE, MUL.
- IDLE, start_i=1, non-MUL code: at edge E0, result_o/zero_o written, done_o=1 during the following cycle; stay IDLE. Back-to-back starts give done_o every cycle.
- IDLE, start_i=1, ctrl_i=1111: at E0 latch mcand=A, mplier=B, acc=0, cnt=0, go to MUL. No done_o for this edge.
- MUL, each edge:
  - if mplier[0], acc += mcand
  - mcand <<= 1, mplier >>= 1, cnt++
  - Finish when the shifted mplier==0 or cnt reaches WIDTH-1 (the WIDTH-th step). On finish, result_o=new acc, zero_o updated, done_o=1 next cycle, go to IDLE.
  - Latency: k edges after E0, where k = max(1, index of highest set bit of B + 1). B=0 gives k=1; B[WIDTH-1]=1 gives k=WIDTH.
- busy_o = (state==MUL), combinational from the state register. It is high for k cycles and falls in the same cycle done_o rises.
- start_i while busy_o=1 is ignored entirely; upstream must stall its pipeline on busy_o. start_i in the done_o cycle is accepted, since the block is already IDLE.
- ctrl_i/src*_i changes during MUL have no effect; operands are latched at E0.
- done_o never asserts without a preceding accepted start_i.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001 -> one cycle later done_o=1, result_o=0x80000000, zero_o=0, busy_o stays 0.
- SUB A=5, B=5 -> result_o=0, zero_o=1. Next cycle SLT A=0xFFFFFFFF, B=1 -> result_o=1. done_o high two consecutive cycles.
- MUL A=0x0000FFFF, B=0x00010001 -> busy_o high 17 cycles, then done_o with result_o=0xFFFFFFFF. MUL A=3, B=0x80000000 -> 32 cycles, result_o=0x80000000.
- MUL A=0x1234, B=0 -> busy_o 1 cycle, result_o=0, zero_o=1. Then ctrl_i=1010 -> result_o=0, zero_o=1, done_o pulse.
- During MUL A=7, B=6, drive start_i=1 ADD 1+1 every cycle -> only one done_o while busy, result_o=42 (0x2A). The ADD asserted in the done_o cycle is accepted; next done_o gives result_o=2.
- MUL A=5, B=0xFFFFFFFF, assert rst_i after 10 busy cycles -> next cycle busy_o=0, result_o=0, zero_o=0, no done_o. A following ADD 2+3 returns 5 with 1-cycle latency.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. It takes the 4-bit ALU control code from the ALU control
// decoder and the two operands from the ID/EX register. Logic ops, ADD, SUB
// and SLT produce a registered result one cycle after the request. MUL runs
// as an iterative radix-2 shift-add that stops early once the remaining
// multiplier bits are all zero. While it runs, busy_o tells upstream to stall.
//
// Ports:
//   clk_i     in   1      clock; all state changes on the rising edge
//   rst_i     in   1      synchronous active-high reset
//   start_i   in   1      operation request, sampled only while idle
//   ctrl_i    in   4      ALU control code
//   src1_i    in   WIDTH  operand A (multiplicand for MUL)
//   src2_i    in   WIDTH  operand B (multiplier for MUL)
//   result_o  out  WIDTH  registered result, held until the next done_o
//   zero_o    out  1      registered (result_o == 0)
//   done_o    out  1      one-cycle pulse: result_o/zero_o just updated
//   busy_o    out  1      high while a multiply is in progress
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] CODE_AND = 4'b0000;
  localparam logic [3:0] CODE_OR  = 4'b0001;
  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;
  localparam logic [3:0] CODE_SLT = 4'b0111;
  localparam logic [3:0] CODE_MUL = 4'b1111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   mcand, next_mcand;
  logic [WIDTH-1:0]   mplier, next_mplier;
  logic [WIDTH-1:0]   acc, next_acc;
  logic [CNT_W-1:0]   cnt, next_cnt;
  logic [WIDTH-1:0]   next_result;
  logic               next_zero;
  logic               next_done;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   step_sum;
  logic [WIDTH-1:0]   shifted_mplier;

  assign busy_o = (state == MUL);

  // Single-cycle datapath. Unknown codes, and MUL itself, yield zero here.
  // MUL never takes this result because it goes through the iterative path.
  always_comb begin
    alu_res = '0;
    unique case (ctrl_i)
      CODE_AND: alu_res = src1_i & src2_i;
      CODE_OR:  alu_res = src1_i | src2_i;
      CODE_ADD: alu_res = src1_i + src2_i;
      CODE_SUB: alu_res = src1_i - src2_i;
      CODE_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default:  alu_res = '0;
    endcase
  end

  // One multiply step: conditionally add the multiplicand, then check the
  // multiplier as it will look after the shift so that we can stop early.
  always_comb begin
    step_sum       = acc + (mplier[0] ? mcand : '0);
    shifted_mplier = mplier >> 1;
  end

  // Next-state and next-output logic. Every value defaults to holding, so the
  // result stays put between operations and done_o falls back to zero.
  always_comb begin
    next_state  = state;
    next_mcand  = mcand;
    next_mplier = mplier;
    next_acc    = acc;
    next_cnt    = cnt;
    next_result = result_o;
    next_zero   = zero_o;
    next_done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (ctrl_i == CODE_MUL) begin
            next_mcand  = src1_i;
            next_mplier = src2_i;
            next_acc    = '0;
            next_cnt    = '0;
            next_state  = MUL;
          end else begin
            next_result = alu_res;
            next_zero   = (alu_res == '0);
            next_done   = 1'b1;
          end
        end
      end
      MUL: begin
        next_acc    = step_sum;
        next_mcand  = mcand << 1;
        next_mplier = shifted_mplier;
        next_cnt    = cnt + CNT_W'(1);
        // The count check covers a multiplier whose top bit is set, where
        // the shifted value only reaches zero on the final step.
        if ((shifted_mplier == '0) || (cnt == CNT_W'(WIDTH-1))) begin
          next_result = step_sum;
          next_zero   = (step_sum == '0);
          next_done   = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and output registers. Reset also aborts a multiply in flight
  // without producing a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= next_state;
      mcand    <= next_mcand;
      mplier   <= next_mplier;
      acc      <= next_acc;
      cnt      <= next_cnt;
      result_o <= next_result;
      zero_o   <= next_zero;
      done_o   <= next_done;
    end
  end

endmodule
